pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the pipelined RV32I core. It replaces the fixed two-stage forwarding unit and the tied-off stall. It keeps its own shift pipeline of in-flight writer records after EX, and from those records it produces per-operand forwarding selects, load-use and multi-cycle stalls, redirect flush, and a stall performance counter. It sits beside the EX stage; the core's operand muxes index the post-EX stage results with FWD_SEL1/FWD_SEL2.

## Interface
- STAGES, 2: number of post-EX stages tracked (stage 1 = EM, stage STAGES = MW); legal 1..4.
- LOAD_STAGE, 2: first stage whose value is valid for a load record; legal 1..STAGES.
- SEL_W, $clog2(STAGES+1): width of the forwarding selects.
- CLK  in  1  clock; all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- EX_VALID  in  1  EX holds a real instruction, not a bubble.
- EX_RD  in  5  EX destination register.
- EX_REGWRT  in  1  EX instruction writes EX_RD.
- EX_ISLOAD  in  1  EX instruction is a load.
- EX_RS1, EX_RS2  in  5 each  EX source registers.
- EX_USE_RS1, EX_USE_RS2  in  1 each  the source is actually read.
- EX_REDIRECT  in  1  taken branch, JAL or JALR resolved in EX.
- EX_MC_BUSY  in  1  a multi-cycle EX operation has not finished.
- FWD_SEL1, FWD_SEL2  out  SEL_W  0 = DE register value; k = result held in post-EX stage k.
- STALL  out  1  freeze F/D/E; insert a bubble into stage 1.
- FLUSH  out  1  kill the F/D and D/E contents.
- STALL_CNT  out  32  number of stalled cycles, saturating.

## Operation
- Record per stage k: valid, rd[4:0], regwrt, isload.
- A record is a candidate for source s when: valid, regwrt, rd == s, rd != 0, and the source's USE bit is set.
- A record is ready at stage k when !isload, or when k >= LOAD_STAGE.
- Forward select for each source: take the youngest candidate (lowest k).
  - Candidate is ready: FWD_SEL = k.
  - Candidate is not ready: raise a data hazard. FWD_SEL = 0 is don't-care while STALL is high.
  - No candidate: FWD_SEL = 0.
- Older candidates never override a younger one, even when the younger one is not ready.
- STALL = data hazard on either source OR EX_MC_BUSY.
- FLUSH = EX_REDIRECT & ~STALL. A redirect under stall is held by the core and takes effect in the first unstalled cycle.
- Record shift on each clock edge:
  - Stage 1 takes {EX_VALID, EX_RD, EX_REGWRT, EX_ISLOAD} when !STALL.
  - Stage 1 takes an invalid record (bubble) when STALL.
  - Stage k>1 always takes stage k-1.
- STALL_CNT increments on every cycle with STALL high and saturates at 0xFFFF_FFFF.
- RESET: all records invalid, STALL_CNT = 0. While RESET is high, STALL, FLUSH and both FWD_SELs are forced to 0.

## Timing
- FWD_SEL*, STALL and FLUSH are combinational from the current EX inputs and the registered records; they take effect in the same cycle.
- Load-use stall length is LOAD_STAGE − k cycles, where k is the stage of the matching load. With defaults, a load followed immediately by a dependent instruction stalls 1 cycle, then forwards from stage 2.
- EX_MC_BUSY stalls for exactly as many cycles as it is high; one bubble per stalled cycle enters stage 1.
- Register-file write-through of the last stage is the core's job. A record leaving stage STAGES is no longer visible to this block.
- Reset asserted mid-stall: outputs drop to 0 in that cycle. The cycle after RESET deasserts shows empty records and no stall.
- Simultaneous redirect and data hazard: STALL = 1, FLUSH = 0.
- Simultaneous redirect and EX_MC_BUSY: STALL = 1, FLUSH = 0.

## Structure
- Shared package pipe_pkg holds:
  - FWD_RF = 0.
  - The stage-record struct typedef {valid, rd, regwrt, isload}.
  - The X0 register index constant.
- Sub-module hazard_match: a priority search over the STAGES records for one source, returning {hit, ready, k}. It is instantiated twice, once for RS1 and once for RS2.
- Top level holds the record shift, the stall/flush logic and STALL_CNT.

## Test plan
- add x5 followed immediately by add x6,x5,x5 (defaults) -> FWD_SEL1 = FWD_SEL2 = 1, STALL = 0. One cycle later a third instruction reading x5 -> FWD_SEL = 2.
- lw x7 followed immediately by add using x7 (LOAD_STAGE = 2) -> STALL = 1 for 1 cycle, stage 1 receives a bubble, next cycle FWD_SEL1 = 2, STALL_CNT = 1.
- Writer with rd = x0 followed by a reader of x0 -> FWD_SEL = 0, no stall.
- x5 written at both stage 1 and stage 2, EX reads x5 -> FWD_SEL1 = 1. Repeat with stage 1 holding an unready load -> STALL = 1, and the stage-2 value is not used.
- EX_REDIRECT pulse with no hazard -> FLUSH = 1 for one cycle. Redirect with EX_MC_BUSY high for 3 cycles -> FLUSH = 0 for 3 cycles, then FLUSH = 1 on the cycle busy drops, STALL_CNT = 3.
- RESET asserted during a load-use stall -> same cycle STALL = 0 and both FWD_SELs = 0. After release, records are empty and STALL_CNT = 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_pkg;

  localparam int unsigned FWD_RF = 0;
  localparam logic [4:0]  X0     = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrt;
    logic       isload;
  } stage_rec_t;

endpackage

// File: rtl/hazard_match.sv
// Priority search over post-EX writer records for one source register.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int unsigned STAGES     = 2,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned SEL_W      = $clog2(STAGES + 1)
) (
  input  stage_rec_t [STAGES-1:0] i_recs,
  input  logic [4:0]              i_src,
  input  logic                    i_use,
  output logic                    o_hit,
  output logic                    o_ready,
  output logic [SEL_W-1:0]        o_k
);

  // Index 0 holds stage 1; the first hit wins so younger records shadow older ones.
  always_comb begin
    o_hit   = 1'b0;
    o_ready = 1'b0;
    o_k     = SEL_W'(FWD_RF);
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (!o_hit && i_use && i_recs[i].valid && i_recs[i].regwrt &&
          i_recs[i].rd == i_src && i_recs[i].rd != X0) begin
        o_hit   = 1'b1;
        o_ready = !i_recs[i].isload || ((i + 1) >= LOAD_STAGE);
        o_k     = SEL_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: writer record shift, forwarding selects, stall/flush and stall counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned STAGES     = 2,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned SEL_W      = $clog2(STAGES + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ex_valid,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_regwrt,
  input  logic             i_ex_isload,
  input  logic [4:0]       i_ex_rs1,
  input  logic [4:0]       i_ex_rs2,
  input  logic             i_ex_use_rs1,
  input  logic             i_ex_use_rs2,
  input  logic             i_ex_redirect,
  input  logic             i_ex_mc_busy,
  output logic [SEL_W-1:0] o_fwd_sel1,
  output logic [SEL_W-1:0] o_fwd_sel2,
  output logic             o_stall,
  output logic             o_flush,
  output logic [31:0]      o_stall_cnt
);

  stage_rec_t [STAGES-1:0] r_recs;
  logic [31:0]             r_stall_cnt;

  logic             w_hit1, w_rdy1, w_hit2, w_rdy2;
  logic [SEL_W-1:0] w_k1, w_k2;
  logic             w_hazard;

  hazard_match #(
    .STAGES    (STAGES),
    .LOAD_STAGE(LOAD_STAGE),
    .SEL_W     (SEL_W)
  ) u_match_rs1 (
    .i_recs (r_recs),
    .i_src  (i_ex_rs1),
    .i_use  (i_ex_use_rs1),
    .o_hit  (w_hit1),
    .o_ready(w_rdy1),
    .o_k    (w_k1)
  );

  hazard_match #(
    .STAGES    (STAGES),
    .LOAD_STAGE(LOAD_STAGE),
    .SEL_W     (SEL_W)
  ) u_match_rs2 (
    .i_recs (r_recs),
    .i_src  (i_ex_rs2),
    .i_use  (i_ex_use_rs2),
    .o_hit  (w_hit2),
    .o_ready(w_rdy2),
    .o_k    (w_k2)
  );

  always_comb begin
    w_hazard   = (w_hit1 && !w_rdy1) || (w_hit2 && !w_rdy2);
    o_stall    = 1'b0;
    o_flush    = 1'b0;
    o_fwd_sel1 = SEL_W'(FWD_RF);
    o_fwd_sel2 = SEL_W'(FWD_RF);
    if (!i_reset) begin
      o_stall = w_hazard || i_ex_mc_busy;
      o_flush = i_ex_redirect && !o_stall;
      if (w_hit1 && w_rdy1) o_fwd_sel1 = w_k1;
      if (w_hit2 && w_rdy2) o_fwd_sel2 = w_k2;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_recs      <= '0;
      r_stall_cnt <= '0;
    end else begin
      // A stall freezes EX, so a bubble enters stage 1 in place of the held instruction.
      if (o_stall) r_recs[0] <= '0;
      else         r_recs[0] <= '{valid: i_ex_valid, rd: i_ex_rd, regwrt: i_ex_regwrt, isload: i_ex_isload};
      for (int unsigned k = 1; k < STAGES; k++) r_recs[k] <= r_recs[k-1];
      if (o_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with default parameters.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_regwrt, ex_isload, use1, use2, redirect, mc_busy;
  logic [4:0]  ex_rd, rs1, rs2;
  logic [1:0]  sel1, sel2;
  logic        stall, flush;
  logic [31:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .STAGES    (2),
    .LOAD_STAGE(2)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_ex_valid   (ex_valid),
    .i_ex_rd      (ex_rd),
    .i_ex_regwrt  (ex_regwrt),
    .i_ex_isload  (ex_isload),
    .i_ex_rs1     (rs1),
    .i_ex_rs2     (rs2),
    .i_ex_use_rs1 (use1),
    .i_ex_use_rs2 (use2),
    .i_ex_redirect(redirect),
    .i_ex_mc_busy (mc_busy),
    .o_fwd_sel1   (sel1),
    .o_fwd_sel2   (sel2),
    .o_stall      (stall),
    .o_flush      (flush),
    .o_stall_cnt  (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                        input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2);
    ex_valid = v; ex_rd = rd; ex_regwrt = wr; ex_isload = ld;
    rs1 = s1; use1 = u1; rs2 = s2; use2 = u2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; mc_busy = 1'b0;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 0);
    check("rst_cnt", stall_cnt, 0);
    reset = 1'b0;

    // add x5 then add x6,x5,x5 then reader of x5
    set_ex(1, 5, 1, 0, 0, 0, 0, 0); tick();
    set_ex(1, 6, 1, 0, 5, 1, 5, 1);
    check("fwd_em_sel1", sel1, 1);
    check("fwd_em_sel2", sel2, 1);
    check("fwd_em_stall", stall, 0);
    tick();
    set_ex(1, 7, 1, 0, 5, 1, 0, 0);
    check("fwd_mw_sel1", sel1, 2);
    check("fwd_mw_stall", stall, 0);
    tick();

    // x0 writer then x0 reader
    set_ex(1, 0, 1, 0, 0, 0, 0, 0); tick();
    set_ex(1, 8, 1, 0, 0, 1, 0, 1);
    check("x0_sel1", sel1, 0);
    check("x0_sel2", sel2, 0);
    check("x0_stall", stall, 0);
    tick();

    // x5 in both stages: youngest wins
    set_ex(1, 5, 1, 0, 0, 0, 0, 0); tick();
    set_ex(1, 5, 1, 0, 0, 0, 0, 0); tick();
    set_ex(1, 9, 1, 0, 5, 1, 6, 1);
    check("young_sel1", sel1, 1);
    check("young_sel2", sel2, 0);
    tick();

    // add x5 then lw x5: unready load shadows ready older x5
    set_ex(1, 5, 1, 0, 0, 0, 0, 0); tick();
    set_ex(1, 5, 1, 1, 0, 0, 0, 0); tick();
    set_ex(1, 10, 1, 0, 5, 1, 0, 0);
    check("shadow_stall", stall, 1);
    check("shadow_cnt0", stall_cnt, 0);
    tick();
    check("shadow_held_stall", stall, 0);
    check("shadow_held_sel1", sel1, 2);
    check("shadow_cnt1", stall_cnt, 1);
    tick();

    // lw x7 then dependent add; redirect under the stall must not flush
    set_ex(1, 7, 1, 1, 0, 0, 0, 0); tick();
    set_ex(1, 11, 1, 0, 7, 1, 7, 1);
    redirect = 1'b1; #1;
    check("lu_stall", stall, 1);
    check("lu_redir_flush", flush, 0);
    tick();
    check("lu_held_stall", stall, 0);
    check("lu_bubble_sel1", sel1, 2);
    check("lu_sel2", sel2, 2);
    check("lu_flush_late", flush, 1);
    check("lu_cnt", stall_cnt, 2);
    redirect = 1'b0; tick();

    // plain redirect pulse
    set_ex(1, 0, 0, 0, 0, 0, 0, 0);
    redirect = 1'b1; #1;
    check("redir_flush", flush, 1);
    check("redir_stall", stall, 0);
    tick();
    redirect = 1'b0; #1;
    check("redir_flush_off", flush, 0);

    // redirect with 3 busy cycles
    redirect = 1'b1; mc_busy = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      check("mc_stall", stall, 1);
      check("mc_flush", flush, 0);
      tick();
    end
    mc_busy = 1'b0; #1;
    check("mc_release_flush", flush, 1);
    check("mc_release_stall", stall, 0);
    check("mc_cnt", stall_cnt, 5);
    tick();
    redirect = 1'b0;

    // reset during load-use stall
    set_ex(1, 7, 1, 1, 0, 0, 0, 0); tick();
    set_ex(1, 12, 1, 0, 7, 1, 7, 1);
    check("rl_stall_pre", stall, 1);
    reset = 1'b1; #1;
    check("rl_stall", stall, 0);
    check("rl_sel1", sel1, 0);
    check("rl_sel2", sel2, 0);
    tick();
    reset = 1'b0; #1;
    check("rl_post_stall", stall, 0);
    check("rl_post_sel1", sel1, 0);
    check("rl_post_cnt", stall_cnt, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
